// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation datapath blocks.
package rsa_pkg;

    localparam int DEF_W_IN  = 8;
    localparam int DEF_W_PHI = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_DIV   = 3'd3,
        S_SWAP  = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/rsa_priv_keygen.sv
// Private-exponent generator: d = e^-1 mod (p-1)(q-1) via iterative
// extended Euclid, one restoring-division bit per cycle.
//
// state | meaning
// IDLE  | wait for start, latch p/q/e
// INIT  | phi = (p-1)(q-1), seed remainders and coefficients
// CHECK | reject p<2, q<2, e==0
// DIV   | one quotient bit per cycle, k = W_PHI-1 .. 0
// SWAP  | rotate (r0,r1) and (t0,t1); stop when remainder is 0
// FIX   | gcd check, map coefficient into [0, phi)
// DONE  | finish pulse
module rsa_priv_keygen
    import rsa_pkg::*;
#(
    parameter int W_IN  = DEF_W_IN,
    parameter int W_PHI = DEF_W_PHI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_IN-1:0]  p,
    input  logic [W_IN-1:0]  q,
    input  logic [W_IN-1:0]  e,
    output logic [W_PHI-1:0] d,
    output logic             err,
    output logic             busy,
    output logic             finish
);

    localparam int T_W = W_PHI + 2;
    localparam int K_W = $clog2(W_PHI);

    state_t state, state_nx;

    logic [W_IN-1:0]        p_r, q_r, e_r;
    logic [W_PHI-1:0]       phi, r0, r1;
    logic signed [T_W-1:0]  t0, t1;
    logic [K_W-1:0]         k;

    // Double-width compare so r1<<k never loses bits.
    logic [2*W_PHI-1:0]     r1_sh;
    logic                   sub_ok;
    logic                   invalid;
    logic signed [T_W-1:0]  t0_wrap;

    assign r1_sh   = {{W_PHI{1'b0}}, r1} << k;
    assign sub_ok  = ({{W_PHI{1'b0}}, r0} >= r1_sh);
    assign invalid = (p_r < W_IN'(2)) || (q_r < W_IN'(2)) || (e_r == '0);
    assign t0_wrap = t0 + $signed({2'b00, phi});

    assign busy   = (state != S_IDLE);
    assign finish = (state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_INIT;
            S_INIT:  state_nx = S_CHECK;
            S_CHECK: state_nx = invalid ? S_DONE : S_DIV;
            S_DIV:   if (k == '0) state_nx = S_SWAP;
            S_SWAP:  state_nx = (r0 == '0) ? S_FIX : S_DIV;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r <= '0; q_r <= '0; e_r <= '0;
            phi <= '0; r0 <= '0; r1 <= '0;
            t0  <= '0; t1 <= '0; k <= '0;
            d   <= '0; err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    p_r <= p; q_r <= q; e_r <= e;
                end
                S_INIT: begin
                    phi <= W_PHI'(p_r - 1'b1) * W_PHI'(q_r - 1'b1);
                    r0  <= W_PHI'(p_r - 1'b1) * W_PHI'(q_r - 1'b1);
                    r1  <= W_PHI'(e_r);
                    t0  <= '0;
                    t1  <= T_W'(1);
                end
                S_CHECK: begin
                    if (invalid) begin
                        err <= 1'b1;
                        d   <= '0;
                    end
                    k <= K_W'(W_PHI - 1);
                end
                S_DIV: begin
                    if (sub_ok) begin
                        r0 <= r0 - r1_sh[W_PHI-1:0];
                        t0 <= t0 - (t1 <<< k);
                    end
                    k <= k - 1'b1;
                end
                S_SWAP: begin
                    r0 <= r1; r1 <= r0;
                    t0 <= t1; t1 <= t0;
                    k  <= K_W'(W_PHI - 1);
                end
                S_FIX: begin
                    if (r0 != W_PHI'(1)) begin
                        err <= 1'b1;
                        d   <= '0;
                    end else begin
                        err <= 1'b0;
                        // Everything is congruent to 0 mod 1.
                        if (phi == W_PHI'(1))  d <= '0;
                        else if (t0 >= 0)      d <= t0[W_PHI-1:0];
                        else                   d <= t0_wrap[W_PHI-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_priv_keygen.sv
// Directed bench for rsa_priv_keygen.
module tb_rsa_priv_keygen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  p = '0, q = '0, e = '0;
    logic [15:0] d;
    logic        err, busy, finish;

    int total = 0;
    int bad   = 0;

    rsa_priv_keygen dut (
        .clk(clk), .rst(rst), .start(start),
        .p(p), .q(q), .e(e),
        .d(d), .err(err), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one request and wait for finish; inputs change on negedge.
    // inj=1 pulses a second start with other operands while busy.
    task automatic run_op(input string tag, input logic [7:0] pp, input logic [7:0] qq,
                          input logic [7:0] ee, input int exp_d, input int exp_err,
                          input int exp_lat, input bit inj);
        int lat;
        bit busy_ok;
        bit seen;
        @(negedge clk);
        p = pp; q = qq; e = ee; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        seen = 1'b0;
        while (lat < 1000) begin
            if (!busy) busy_ok = 1'b0;
            if (finish) begin
                seen = 1'b1;
                break;
            end
            if (inj && lat == 10) begin
                p = 8'd13; q = 8'd11; e = 8'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_finish_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, "_d"}, 32'(d), 32'(exp_d));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_finish_width"}, 32'(finish), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int extra;

        #1;
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // phi=3120, N=4
        run_op("t61_53_17", 8'd61, 8'd53, 8'd17, 2753, 0, 72, 1'b0);
        // d holds while idle
        repeat (5) @(negedge clk);
        chk("hold_d", 32'(d), 32'd2753);

        // phi=120, N=2
        run_op("t13_11_7", 8'd13, 8'd11, 8'd7, 103, 0, 38, 1'b0);
        // gcd 6, N=1
        run_op("t13_11_6", 8'd13, 8'd11, 8'd6, 0, 1, 21, 1'b0);
        // e > phi=8, N=5
        run_op("t3_5_11", 8'd3, 8'd5, 8'd11, 3, 0, 89, 1'b0);
        // e=1, N=1
        run_op("t13_11_1", 8'd13, 8'd11, 8'd1, 1, 0, 21, 1'b0);
        // invalid p
        run_op("t1_11_7", 8'd1, 8'd11, 8'd7, 0, 1, 3, 1'b0);
        // invalid e
        run_op("t13_11_0", 8'd13, 8'd11, 8'd0, 0, 1, 3, 1'b0);

        // second start while busy is ignored
        run_op("busy_ign", 8'd61, 8'd53, 8'd17, 2753, 0, 72, 1'b1);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (finish) extra++;
        end
        chk("busy_ign_no_2nd_finish", 32'(extra), 32'd0);

        // start coincident with finish is ignored
        @(negedge clk);
        p = 8'd1; q = 8'd11; e = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);   // now in DONE
        chk("coinc_finish_hi", 32'(finish), 32'd1);
        p = 8'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("coinc_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("coinc_still_idle", 32'(busy), 32'd0);

        // reset mid-DIV, after a good result has been loaded
        run_op("pre_rst", 8'd61, 8'd53, 8'd17, 2753, 0, 72, 1'b0);
        @(negedge clk);
        p = 8'd61; q = 8'd53; e = 8'd17; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_d", 32'(d), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 8'd13, 8'd11, 8'd7, 103, 0, 38, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
